// File: rtl/tmds_pkg.sv
// TMDS token constants, TERC4 code table and alignment FSM states shared by the channel decoder.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOK_00 = 10'h354;
  localparam logic [9:0] CTRL_TOK_01 = 10'h0AB;
  localparam logic [9:0] CTRL_TOK_10 = 10'h154;
  localparam logic [9:0] CTRL_TOK_11 = 10'h2AB;

  localparam logic [9:0] GUARD_A = 10'h2CC;
  localparam logic [9:0] GUARD_B = 10'h133;

  // Indexed by the nibble each code carries.
  localparam logic [9:0] TERC4_TABLE [16] = '{
    10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
    10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3
  };

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_SLIP,
    ST_SLIP_HOLD,
    ST_LOCKED
  } state_e;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational classification of one 10-bit TMDS symbol: control, video data, TERC4 and guard.
// Zero latency, no flow control; the caller registers the results.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] sym_i,
  output logic       is_ctrl_o,
  output logic [1:0] ctrl_o,
  output logic [7:0] data_o,
  output logic [3:0] terc4_o,
  output logic       terc4_valid_o,
  output logic       guard_o
);

  logic [7:0] q;

  always_comb begin
    is_ctrl_o = 1'b1;
    ctrl_o    = 2'b00;
    case (sym_i)
      CTRL_TOK_00: ctrl_o = 2'b00;
      CTRL_TOK_01: ctrl_o = 2'b01;
      CTRL_TOK_10: ctrl_o = 2'b10;
      CTRL_TOK_11: ctrl_o = 2'b11;
      default:     is_ctrl_o = 1'b0;
    endcase

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    q         = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];
    data_o    = 8'h00;
    data_o[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      data_o[i] = sym_i[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end

    terc4_o       = 4'h0;
    terc4_valid_o = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (sym_i == TERC4_TABLE[i]) begin
        terc4_o       = 4'(i);
        terc4_valid_o = 1'b1;
      end
    end

    guard_o = (sym_i == GUARD_A) || (sym_i == GUARD_B);
  end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS channel: 2-cycle decode pipeline plus control-token word alignment with bitslip requests.
// No backpressure: one symbol per clk; consumers qualify decode outputs with aligned.
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int WINDOW    = 4096,
  parameter int RUN_MIN   = 8,
  parameter int SLIP_WAIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] sym_in,
  output logic       bitslip,
  output logic       aligned,
  output logic       de,
  output logic [1:0] ctrl,
  output logic [7:0] data,
  output logic [3:0] terc4,
  output logic       terc4_valid,
  output logic       guard
);

  localparam int WIN_W  = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam int RUN_W  = $clog2(RUN_MIN + 1);
  localparam int HOLD_W = $clog2(SLIP_WAIT + 1);

  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [RUN_W-1:0]  RUN_FULL  = RUN_W'(RUN_MIN);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SLIP_WAIT - 1);

  logic [9:0] sym_q;
  logic       dec_is_ctrl, dec_tv, dec_guard;
  logic [1:0] dec_ctrl;
  logic [7:0] dec_data;
  logic [3:0] dec_terc4;

  logic       de_q, tv_q, guard_q;
  logic [1:0] ctrl_q;
  logic [7:0] data_q;
  logic [3:0] terc4_q;

  state_e            state_q;
  logic [WIN_W-1:0]  win_q;
  logic [HOLD_W-1:0] hold_q;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [1:0]        last_tok_q, last_tok_d;
  logic              bitslip_q, aligned_q;
  logic              run_full;

  tmds_symbol_decode u_dec (
    .sym_i         (sym_q),
    .is_ctrl_o     (dec_is_ctrl),
    .ctrl_o        (dec_ctrl),
    .data_o        (dec_data),
    .terc4_o       (dec_terc4),
    .terc4_valid_o (dec_tv),
    .guard_o       (dec_guard)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sym_q   <= '0;
      de_q    <= 1'b0;
      ctrl_q  <= 2'b00;
      data_q  <= '0;
      terc4_q <= '0;
      tv_q    <= 1'b0;
      guard_q <= 1'b0;
    end else begin
      sym_q   <= sym_in;
      de_q    <= ~dec_is_ctrl;
      if (dec_is_ctrl) ctrl_q <= dec_ctrl;
      data_q  <= dec_data;
      terc4_q <= dec_terc4;
      tv_q    <= dec_tv;
      guard_q <= dec_guard;
    end
  end

  // Run of identical control tokens, judged on the first pipeline stage.
  always_comb begin
    run_d      = run_q;
    last_tok_d = last_tok_q;
    if (state_q == ST_SLIP_HOLD) begin
      run_d = '0;
    end else if (dec_is_ctrl) begin
      last_tok_d = dec_ctrl;
      if (run_q != '0 && dec_ctrl == last_tok_q) begin
        if (run_q != RUN_FULL) run_d = run_q + 1'b1;
      end else begin
        run_d = RUN_W'(1);
      end
    end else begin
      run_d = '0;
    end
  end

  assign run_full = (run_d == RUN_FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_SEARCH;
      win_q      <= '0;
      hold_q     <= '0;
      run_q      <= '0;
      last_tok_q <= 2'b00;
      bitslip_q  <= 1'b0;
      aligned_q  <= 1'b0;
    end else begin
      run_q      <= run_d;
      last_tok_q <= last_tok_d;
      bitslip_q  <= 1'b0;
      case (state_q)
        ST_SEARCH: begin
          if (run_full) begin
            state_q   <= ST_LOCKED;
            win_q     <= '0;
            aligned_q <= 1'b1;
          end else if (win_q == WIN_LAST) begin
            state_q   <= ST_SLIP;
            win_q     <= '0;
            bitslip_q <= 1'b1;
          end else begin
            win_q <= win_q + 1'b1;
          end
        end
        ST_SLIP: begin
          state_q <= ST_SLIP_HOLD;
          hold_q  <= '0;
        end
        ST_SLIP_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_q <= ST_SEARCH;
            win_q   <= '0;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (run_full) begin
            win_q <= '0;
          end else if (win_q == WIN_LAST) begin
            state_q   <= ST_SEARCH;
            win_q     <= '0;
            aligned_q <= 1'b0;
          end else begin
            win_q <= win_q + 1'b1;
          end
        end
        default: state_q <= ST_SEARCH;
      endcase
    end
  end

  assign bitslip     = bitslip_q;
  assign aligned     = aligned_q;
  assign de          = de_q;
  assign ctrl        = ctrl_q;
  assign data        = data_q;
  assign terc4       = terc4_q;
  assign terc4_valid = tv_q;
  assign guard       = guard_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboarded bench for tmds_channel_decoder with a shortened search window.
module tb_tmds_channel_decoder;

  localparam int WINDOW    = 64;
  localparam int RUN_MIN   = 8;
  localparam int SLIP_WAIT = 16;

  localparam logic [9:0] T4 [16] = '{
    10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
    10'h2CC, 10'h139, 10'h19C, 10'h2C6, 10'h28E, 10'h271, 10'h163, 10'h2C3
  };

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] sym_in = '0;
  logic       bitslip, aligned, de, terc4_valid, guard;
  logic [1:0] ctrl;
  logic [7:0] data;
  logic [3:0] terc4;

  tmds_channel_decoder #(.WINDOW(WINDOW), .RUN_MIN(RUN_MIN), .SLIP_WAIT(SLIP_WAIT)) dut (
    .clk         (clk),
    .reset       (reset),
    .sym_in      (sym_in),
    .bitslip     (bitslip),
    .aligned     (aligned),
    .de          (de),
    .ctrl        (ctrl),
    .data        (data),
    .terc4       (terc4),
    .terc4_valid (terc4_valid),
    .guard       (guard)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [9:0] sym;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic [3:0] terc4;
    logic       tv;
    logic       guard;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc = 0;
  int         slip_cnt = 0;
  logic       prev_bs = 1'b0;
  logic [1:0] model_ctrl = 2'b00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (bitslip) begin
      check("bitslip_one_cycle", prev_bs, 0);
      slip_cnt++;
    end
    prev_bs = bitslip;
    while (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check($sformatf("de[%03h]", e.sym), de, e.de);
      check($sformatf("ctrl[%03h]", e.sym), ctrl, e.ctrl);
      if (e.de) check($sformatf("data[%03h]", e.sym), data, e.data);
      check($sformatf("terc4[%03h]", e.sym), terc4, e.terc4);
      check($sformatf("terc4_valid[%03h]", e.sym), terc4_valid, e.tv);
      check($sformatf("guard[%03h]", e.sym), guard, e.guard);
    end
  end

  task automatic drive(input logic [9:0] s);
    exp_t       e;
    logic [7:0] q;
    @(negedge clk);
    sym_in  = s;
    e.due   = cyc + 2;
    e.sym   = s;
    e.de    = 1'b0;
    case (s)
      10'h354: model_ctrl = 2'b00;
      10'h0AB: model_ctrl = 2'b01;
      10'h154: model_ctrl = 2'b10;
      10'h2AB: model_ctrl = 2'b11;
      default: e.de = 1'b1;
    endcase
    e.ctrl = model_ctrl;
    q = s[9] ? ~s[7:0] : s[7:0];
    e.data[0] = q[0];
    for (int i = 1; i < 8; i++) e.data[i] = s[8] ? (q[i] != q[i-1]) : (q[i] == q[i-1]);
    e.terc4 = 4'h0;
    e.tv    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (T4[i] == s) begin
        e.terc4 = 4'(i);
        e.tv    = 1'b1;
      end
    end
    e.guard = (s == 10'h2CC) || (s == 10'h133);
    sb.push_back(e);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_bitslip"}, bitslip, 0);
    check({pfx, "_aligned"}, aligned, 0);
    check({pfx, "_de"}, de, 0);
    check({pfx, "_ctrl"}, ctrl, 0);
    check({pfx, "_data"}, data, 0);
    check({pfx, "_terc4"}, terc4, 0);
    check({pfx, "_terc4_valid"}, terc4_valid, 0);
    check({pfx, "_guard"}, guard, 0);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    sym_in = '0;
    sb.delete();
    model_ctrl = 2'b00;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int i;
    int s0;
    bit found;

    // Reset values
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    // Decode: data, control, TERC4, guard, random symbols
    drive(10'h100);
    drive(10'h2FF);
    drive(10'h354);
    drive(10'h2AB);
    drive(10'h29C);
    drive(10'h2CC);
    drive(10'h133);
    for (int k = 0; k < 16; k++) drive(T4[k]);
    for (int k = 0; k < 12; k++) drive(10'($urandom_range(0, 1023)));
    repeat (3) @(negedge clk);

    // Lock: 7 tokens is not enough, 8 is
    apply_reset(2);
    s0 = slip_cnt;
    repeat (RUN_MIN - 1) drive(10'h154);
    repeat (4) drive(10'h100);
    check("no_lock_short_run", aligned, 0);
    repeat (RUN_MIN) drive(10'h154);
    found = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (aligned) begin
        found = 1;
        break;
      end
    end
    check("lock_within_3", found, 1);
    repeat (4) drive(10'h154);
    check("lock_held", aligned, 1);
    check("lock_no_bitslip", slip_cnt, s0);

    // Loss of lock on data-only stream
    i = 0;
    while (aligned && i < WINDOW + 10) begin
      drive(10'h100);
      i++;
    end
    check("loss_aligned_low", aligned, 0);
    check("loss_not_early", i >= WINDOW - 2, 1);
    check("loss_not_late", i <= WINDOW + 6, 1);
    check("loss_no_bitslip", slip_cnt, s0);

    // Slip on a rotated stream, then relock once corrected
    apply_reset(2);
    s0 = slip_cnt;
    i = 0;
    while (slip_cnt == s0 && i < WINDOW + 10) begin
      drive(10'h1AA);
      i++;
    end
    check("slip_pulse_seen", slip_cnt, s0 + 1);
    check("slip_not_early", i >= WINDOW - 2, 1);
    check("slip_not_late", i <= WINDOW + 6, 1);
    repeat (SLIP_WAIT + 2) drive(10'h1AA);
    check("slip_hold_quiet", slip_cnt, s0 + 1);
    check("slip_not_aligned", aligned, 0);
    repeat (RUN_MIN) drive(10'h354);
    found = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (aligned) begin
        found = 1;
        break;
      end
    end
    check("relock_after_slip", found, 1);

    // Reset on the bitslip cycle
    apply_reset(2);
    s0 = slip_cnt;
    found = 0;
    for (int k = 0; k < WINDOW + 10; k++) begin
      drive(10'h1AA);
      if (bitslip) begin
        found = 1;
        break;
      end
    end
    check("rst_slip_pulse_seen", found, 1);
    reset = 1'b1;
    sb.delete();
    model_ctrl = 2'b00;
    @(negedge clk);
    check_reset_outputs("rst_slip");
    @(negedge clk);
    reset = 1'b0;
    repeat (20) drive(10'h100);
    check("rst_slip_no_more_pulse", slip_cnt, s0 + 1);

    // Reset during LOCKED
    repeat (RUN_MIN + 4) drive(10'h2AB);
    check("locked_before_reset", aligned, 1);
    check("ctrl_before_reset", ctrl, 3);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    model_ctrl = 2'b00;
    @(negedge clk);
    check_reset_outputs("rst_locked");
    reset = 1'b0;

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
